fifo_rd_ctrl: RTL and testbench

Packet-oriented read controller for the 8-bit synchronous FIFO (`sync_fifo`). It drains the FIFO through its `rd_en`/`data_out`/`empty` port and re-emits the words on a valid/ready stream, framed into packets whose length is given at start. It absorbs the FIFO's one-cycle registered read latency with a 2-entry skid buffer, sustaining one word per cycle with no loss or duplication under arbitrary downstream backpressure. It sits between `sync_fifo` and any downstream consumer (serializer, bus master).

---
 rtl/fifo_rd_pkg.sv | 16 +
 rtl/fifo_rd_skid.sv | 61 ++++++
 rtl/fifo_rd_ctrl.sv | 111 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the packet-oriented FIFO read controller.
package fifo_rd_pkg;

    localparam int DATA_W_DFLT = 8;
    localparam int LEN_W_DFLT  = 8;
    localparam int SKID_DEPTH  = 2;
    localparam int OCC_W       = $clog2(SKID_DEPTH + 1);
    localparam int WORD_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: captures words returned by the FIFO and presents
// them in order on a valid/ready output, reporting its occupancy.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;
    logic              pop;

    assign out_valid = (occ != '0);
    assign out_data  = ent0;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the entries are reset only because the head word is visible
            // on the output port and must read 0 after reset; plain storage
            // arrays elsewhere would normally be left unreset.
            occ  <= '0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // block based on pre-edge values, so ent0 <= ent1 shifts correctly.
            unique case ({push, pop})
                2'b10: begin
                    if (occ == '0) ent0 <= push_data;
                    else           ent1 <= push_data;
                    occ <= occ + OCC_W'(1);
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - OCC_W'(1);
                end
                2'b11: begin
                    // Head leaves while a new word arrives: occupancy is unchanged.
                    if (occ == OCC_W'(1)) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Packet read controller draining sync_fifo onto a valid/ready stream.
// Optional word counter enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int LEN_W  = LEN_W_DFLT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    input  logic [DATA_W-1:0]     fifo_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_last,
    output logic [WORD_CNT_W-1:0] word_cnt
);

    rd_state_t          state;
    rd_state_t          next_state;
    logic [LEN_W:0]     req_left;
    logic [LEN_W:0]     out_left;
    logic [LEN_W:0]     len_load;
    logic               inflight;
    logic               pop;
    logic               final_beat;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W:0]     demand;

    // A length of zero encodes the full 2^LEN_W word packet.
    assign len_load   = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
    assign pop        = m_valid && m_ready;
    assign final_beat = pop && (out_left == (LEN_W + 1)'(1));
    assign busy       = (state != IDLE);
    assign m_last     = m_valid && (out_left == (LEN_W + 1)'(1));

    // Pop only while the buffer can still absorb every word already requested.
    assign demand     = (OCC_W + 1)'(occ) + (OCC_W + 1)'(inflight);
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (req_left != '0) &&
                        (demand < (OCC_W + 1)'(SKID_DEPTH) + (OCC_W + 1)'(pop));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch forms.
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (fifo_rd_en && (req_left == (LEN_W + 1)'(1))) next_state = DRAIN;
            DRAIN:   if (final_beat) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_left <= '0;
            out_left <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            done     <= (state == DRAIN) && final_beat;
            if (state == IDLE) begin
                if (start) begin
                    req_left <= len_load;
                    out_left <= len_load;
                end
            end else begin
                if (fifo_rd_en) req_left <= req_left - (LEN_W + 1)'(1);
                if (pop)        out_left <= out_left - (LEN_W + 1)'(1);
            end
        end
    end

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (fifo_data),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .occ       (occ)
    );

`ifdef FIFO_RD_STATS_EN
    logic [WORD_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   cnt <= '0;
        else if (pop) cnt <= cnt + WORD_CNT_W'(1);
    end

    assign word_cnt = cnt;
`else
    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl driven by a behavioural sync_fifo model.
module tb_fifo_rd_ctrl;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy;
    logic              done;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic [15:0]       word_cnt;

    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;

    logic [DATA_W-1:0] fq[$];
    beat_t             exp_q[$];
    logic [DATA_W-1:0] pkt8[$];

    int   tests = 0;
    int   fails = 0;
    int   rd_pulses = 0;
    int   beats = 0;
    int   beats_since_reset = 0;
    int   done_cnt = 0;
    logic hold_chk = 1'b0;
    logic done_exp = 1'b0;
    logic [DATA_W-1:0] h_data = '0;
    logic h_last = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .word_cnt   (word_cnt)
    );

    // sync_fifo model: registered read data, empty flag updated at the edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fq.delete();
            fifo_data  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && fq.size() != 0) fifo_data <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic monitor();
        beat_t e;
        if (fifo_rd_en) rd_pulses++;
        if (fifo_rd_en && fifo_empty) begin
            tests++; fails++;
            $display("FAIL rd_en_while_empty: fifo_rd_en=%b with fifo_empty=%b, required rd_en=0", fifo_rd_en, fifo_empty);
        end
        if (dut.u_skid.occ > 2'd2) begin
            tests++; fails++;
            $display("FAIL skid_occ: occ=%0d, required <= 2", dut.u_skid.occ);
        end
        if (hold_chk) begin
            tests++;
            if (m_valid !== 1'b1 || m_data !== h_data || m_last !== h_last) begin
                fails++;
                $display("FAIL stall_hold: valid=%b data=%02h last=%b, required valid=1 data=%02h last=%b",
                         m_valid, m_data, m_last, h_data, h_last);
            end
        end
        if (done_exp || done !== 1'b0) begin
            tests++;
            if (done !== done_exp) begin
                fails++;
                $display("FAIL done_pulse: done=%b, required %b", done, done_exp);
            end
        end
        if (done === 1'b1) done_cnt++;
        done_exp = 1'b0;
        if (m_valid && m_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: data=%02h last=%b, required no beat", m_data, m_last);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e.data || m_last !== e.last) begin
                    fails++;
                    $display("FAIL beat: data=%02h last=%b, required data=%02h last=%b", m_data, m_last, e.data, e.last);
                end
                done_exp = e.last;
            end
            beats++;
            beats_since_reset++;
        end
        hold_chk = m_valid && !m_ready;
        h_data   = m_data;
        h_last   = m_last;
    endtask

    // Inputs are changed 1 time unit after a rising edge; outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (reset) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        exp_q.delete();
        hold_chk = 1'b0;
        done_exp = 1'b0;
        beats_since_reset = 0;
    endtask

    task automatic write_words(input logic [DATA_W-1:0] w[$]);
        foreach (w[i]) begin
            wr_en   = 1'b1;
            wr_data = w[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic expect_pkt(input logic [DATA_W-1:0] w[$], input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = w[i];
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_pkt(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (done_cnt < target) begin
            fails++;
            $display("FAIL %s_timeout: done seen %0d times, required %0d within %0d cycles", name, done_cnt, target, budget);
        end
    endtask

    task automatic clear_counts();
        rd_pulses = 0;
        beats     = 0;
        done_cnt  = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, fifo_rd_en, m_valid, m_last, m_data, word_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_values: busy=%b done=%b rd_en=%b valid=%b last=%b data=%02h cnt=%0d, required all 0",
                     busy, done, fifo_rd_en, m_valid, m_last, m_data, word_cnt);
        end
        reset = 1'b1;
        write_words('{8'h11, 8'h22, 8'h33});
        start_pkt(8'd3);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        tests++;
        if ({busy, done, fifo_rd_en, m_valid, m_last, m_data, word_cnt} !== '0) begin
            fails++;
            $display("FAIL async_reset: busy=%b done=%b rd_en=%b valid=%b last=%b data=%02h cnt=%0d, required all 0",
                     busy, done, fifo_rd_en, m_valid, m_last, m_data, word_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (fifo_rd_en !== 1'b0) begin
                fails++;
                $display("FAIL rd_en_in_reset: fifo_rd_en=%b, required 0", fifo_rd_en);
            end
        end
        reset = 1'b1;
        exp_q.delete();
        hold_chk = 1'b0;
        done_exp = 1'b0;
        beats_since_reset = 0;
        clear_counts();
        m_ready = 1'b1;
        repeat (5) tick();
        tests++;
        if (rd_pulses != 0 || m_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_idle: rd_pulses=%0d valid=%b busy=%b, required 0 0 0", rd_pulses, m_valid, busy);
        end
    endtask

    task automatic test_basic();
        clear_counts();
        m_ready = 1'b1;
        write_words(pkt8);
        expect_pkt(pkt8, 8);
        start_pkt(8'd8);
        tests++;
        if (fifo_rd_en !== 1'b1 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_pop: rd_en=%b valid=%b after start edge, required 1 0", fifo_rd_en, m_valid);
        end
        tick();
        tests++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
            fails++;
            $display("FAIL latency_capture: valid=%b rd_en=%b after first read edge, required 0 1", m_valid, fifo_rd_en);
        end
        tick();
        tests++;
        if (m_valid !== 1'b1 || m_data !== 8'h24) begin
            fails++;
            $display("FAIL latency_valid: valid=%b data=%02h, required 1 24", m_valid, m_data);
        end
        repeat (8) tick();
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || beats != 8) begin
            fails++;
            $display("FAIL throughput: done=%b busy=%b beats=%0d, required 1 0 8", done, busy, beats);
        end
        tick();
        tests++;
        if (rd_pulses != 8 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL basic_pops: rd_pulses=%0d left=%0d, required 8 0", rd_pulses, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        clear_counts();
        m_ready = 1'b1;
        write_words(pkt8);
        expect_pkt(pkt8, 8);
        start_pkt(8'd8);
        while (done_cnt < 1 && n < 100) begin
            m_ready = (n % 4 == 0) || (n % 4 == 3);
            tick();
            n++;
        end
        m_ready = 1'b1;
        tests++;
        if (done_cnt != 1 || beats != 8 || rd_pulses != 8 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL backpressure: done=%0d beats=%0d pops=%0d left=%0d, required 1 8 8 0",
                     done_cnt, beats, rd_pulses, exp_q.size());
        end
    endtask

    task automatic test_empty_stall();
        logic [DATA_W-1:0] w[$];
        w = '{8'ha1, 8'hb2, 8'hc3, 8'hd4};
        clear_counts();
        m_ready = 1'b1;
        write_words(w[0:1]);
        expect_pkt(w, 4);
        start_pkt(8'd4);
        repeat (10) tick();
        tests++;
        if (beats != 2 || m_valid !== 1'b0 || busy !== 1'b1 || fifo_rd_en !== 1'b0 || rd_pulses != 2) begin
            fails++;
            $display("FAIL empty_stall: beats=%0d valid=%b busy=%b rd_en=%b pops=%0d, required 2 0 1 0 2",
                     beats, m_valid, busy, fifo_rd_en, rd_pulses);
        end
        write_words(w[2:3]);
        wait_done(1, 30, "empty_resume");
        tests++;
        if (beats != 4 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL empty_resume: beats=%0d left=%0d, required 4 0", beats, exp_q.size());
        end
    endtask

    task automatic test_start_while_busy();
        logic [DATA_W-1:0] w[$];
        w = '{8'h5a, 8'h6b, 8'h7c, 8'h8d};
        clear_counts();
        m_ready = 1'b1;
        write_words(w);
        expect_pkt(w, 4);
        start_pkt(8'd4);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: busy=%b, required 1", busy);
        end
        start_pkt(8'd1);
        wait_done(1, 30, "busy_start");
        repeat (5) tick();
        tests++;
        if (beats != 4 || done_cnt != 1 || busy !== 1'b0 || rd_pulses != 4) begin
            fails++;
            $display("FAIL start_ignored: beats=%0d done=%0d busy=%b pops=%0d, required 4 1 0 4",
                     beats, done_cnt, busy, rd_pulses);
        end
        tests++;
`ifdef FIFO_RD_STATS_EN
        if (word_cnt !== 16'(beats_since_reset)) begin
`else
        if (word_cnt !== 16'd0) begin
`endif
            fails++;
            $display("FAIL word_cnt_mid: word_cnt=%0d, beats since reset %0d", word_cnt, beats_since_reset);
        end
    endtask

    task automatic test_stats();
        logic [DATA_W-1:0] w[$];
        apply_reset();
        clear_counts();
        m_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            w.delete();
            for (int i = 0; i < 256; i++) w.push_back(DATA_W'($urandom));
            write_words(w);
            expect_pkt(w, 256);
            start_pkt(8'd0);
            wait_done(p + 1, 600, "len256");
        end
        tick();
        tests++;
        if (beats != 512 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL len256_beats: beats=%0d left=%0d, required 512 0", beats, exp_q.size());
        end
        tests++;
`ifdef FIFO_RD_STATS_EN
        if (word_cnt !== 16'd512) begin
            fails++;
            $display("FAIL word_cnt: word_cnt=%0d, required 512", word_cnt);
        end
`else
        if (word_cnt !== 16'd0) begin
            fails++;
            $display("FAIL word_cnt: word_cnt=%0d, required 0", word_cnt);
        end
`endif
    endtask

    initial begin
        pkt8 = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0d, 8'h8d, 8'h65, 8'h12};
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_stall();
        test_start_while_busy();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
